// File: rtl/test_csr_bank.sv
// Purpose: host-visible CSR bank; decodes MMIO writes into one-cycle strobes, answers MMIO reads via a tagged response queue.
// Latency: write strobe 1 cycle after mmio_wr_valid; read response 2 cycles after accept (+1 per entry queued ahead).
// Backpressure: mmio_rd_ready drops when queued + in-flight reads fill RSP_DEPTH; writes are never stalled.
// Optional feature: define TEST_CSR_SNAPSHOT_EN to enable coherent shadow reads of CSR 1..NUM_CSRS-1.

// Small synchronous FIFO with occupancy output; push and pop may coincide even when full.
module test_csr_bank_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_rdy,
    output logic                       head_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push;
    logic             pop;

    // Pointer and occupancy update; a pop frees the slot a simultaneous push needs.
    always_comb begin
        pop      = (count_q != '0) && pop_rdy;
        push     = push_vld && ((count_q != CW'(DEPTH)) || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; an empty queue never exposes it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_vld = (count_q != '0);
    assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
endmodule

module test_csr_bank #(
    parameter int NUM_CSRS   = 8,
    parameter int DATA_WIDTH = 64,
    parameter int TID_WIDTH  = 9,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [127:0]                   afu_id,
    input  logic                           mmio_wr_valid,
    input  logic [15:0]                    mmio_wr_addr,
    input  logic [63:0]                    mmio_wr_data,
    input  logic                           mmio_rd_valid,
    output logic                           mmio_rd_ready,
    input  logic [15:0]                    mmio_rd_addr,
    input  logic [TID_WIDTH-1:0]           mmio_rd_tid,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [TID_WIDTH-1:0]           rsp_tid,
    output logic [63:0]                    rsp_data,
    input  logic [NUM_CSRS*DATA_WIDTH-1:0] rd_csr_data,
    output logic [NUM_CSRS-1:0]            wr_csr_en,
    output logic [DATA_WIDTH-1:0]          wr_csr_data
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int RW = TID_WIDTH + 64;

    // Write path state.
    logic [NUM_CSRS-1:0]   wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_dat_q, wr_dat_d;

    // Read stage 1 (accepted request) state.
    logic                  s1_vld_q, s1_vld_d;
    logic [15:0]           s1_addr_q, s1_addr_d;
    logic [TID_WIDTH-1:0]  s1_tid_q, s1_tid_d;

    // Ready is held low until the first edge after reset releases.
    logic                  rdy_en_q, rdy_en_d;

    logic                  rd_accept;
    logic [63:0]           s2_data;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         occ_sum;
    logic [RW-1:0]         head_dat;
    logic                  head_vld;
    logic                  unused_wr_hi;

`ifdef TEST_CSR_SNAPSHOT_EN
    logic [NUM_CSRS*DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic                           unused_shadow_csr0;
`endif

    // Only the low DATA_WIDTH bits of write data reach the test logic.
    assign unused_wr_hi = ^mmio_wr_data;

    // Write decode: one-hot strobe for words 2..NUM_CSRS+1, data captured only on a hit.
    always_comb begin
        wr_en_d  = '0;
        wr_dat_d = wr_dat_q;
        for (int i = 0; i < NUM_CSRS; i++) begin
            if (mmio_wr_valid && (mmio_wr_addr == 16'(i + 2))) begin
                wr_en_d[i] = 1'b1;
                wr_dat_d   = mmio_wr_data[DATA_WIDTH-1:0];
            end
        end
    end

    // Write strobe and data registers; reset clears a pending strobe at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q  <= '0;
            wr_dat_q <= '0;
        end else begin
            wr_en_q  <= wr_en_d;
            wr_dat_q <= wr_dat_d;
        end
    end

    assign wr_csr_en   = wr_en_q;
    assign wr_csr_data = wr_dat_q;

    // Count both queued responses and the one in stage 1 so the push never finds the queue full.
    assign occ_sum       = fifo_count + CW'(s1_vld_q);
    assign mmio_rd_ready = rdy_en_q && (occ_sum < CW'(RSP_DEPTH));
    assign rd_accept     = mmio_rd_valid && mmio_rd_ready;

    // Stage 1 capture: address and tag held until the next accepted request.
    always_comb begin
        rdy_en_d  = 1'b1;
        s1_vld_d  = rd_accept;
        s1_addr_d = s1_addr_q;
        s1_tid_d  = s1_tid_q;
        if (rd_accept) begin
            s1_addr_d = mmio_rd_addr;
            s1_tid_d  = mmio_rd_tid;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_en_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_tid_q  <= '0;
        end else begin
            rdy_en_q  <= rdy_en_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            s1_tid_q  <= s1_tid_d;
        end
    end

    // Stage 2 read mux: AFU ID, CSRs (zero-extended), zero for unmapped words.
    always_comb begin
        s2_data = '0;
        if (s1_addr_q == 16'd0) begin
            s2_data = afu_id[63:0];
        end else if (s1_addr_q == 16'd1) begin
            s2_data = afu_id[127:64];
        end
        for (int i = 0; i < NUM_CSRS; i++) begin
            if (s1_addr_q == 16'(i + 2)) begin
                s2_data = '0;
`ifdef TEST_CSR_SNAPSHOT_EN
                if (i == 0) begin
                    s2_data[DATA_WIDTH-1:0] = rd_csr_data[DATA_WIDTH-1:0];
                end else begin
                    s2_data[DATA_WIDTH-1:0] = shadow_q[i*DATA_WIDTH +: DATA_WIDTH];
                end
`else
                s2_data[DATA_WIDTH-1:0] = rd_csr_data[i*DATA_WIDTH +: DATA_WIDTH];
`endif
            end
        end
    end

`ifdef TEST_CSR_SNAPSHOT_EN
    // CSR 0 read freezes every CSR so later words read back one coherent sample.
    always_comb begin
        shadow_d = shadow_q;
        if (s1_vld_q && (s1_addr_q == 16'd2)) begin
            shadow_d = rd_csr_data;
        end
    end

    // Shadow register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    // CSR 0 is always returned live, so its shadow slice is never read.
    assign unused_shadow_csr0 = ^shadow_q[DATA_WIDTH-1:0];
`endif

    // Response queue; head drives the response port and holds while stalled.
    test_csr_bank_fifo #(
        .WIDTH (RW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (s1_vld_q),
        .push_dat ({s1_tid_q, s2_data}),
        .pop_rdy  (rsp_ready),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign rsp_valid = head_vld;
    assign rsp_tid   = head_dat[RW-1:64];
    assign rsp_data  = head_dat[63:0];
endmodule

// File: tb/tb_test_csr_bank.sv
// Purpose: directed self-checking bench for test_csr_bank (NUM_CSRS=8, DATA_WIDTH=40, RSP_DEPTH=4).
// Latency: checks write strobe at +1 cycle and read response at +2 cycles after accept.
// Backpressure: exercises rsp_ready stall, ready drop after 4 accepts, and reset with queued responses.
module tb_test_csr_bank;
    localparam int NUM = 8;
    localparam int DW  = 40;
    localparam int TW  = 9;

    logic            clk;
    logic            reset_n;
    logic [127:0]    afu_id;
    logic            mmio_wr_valid;
    logic [15:0]     mmio_wr_addr;
    logic [63:0]     mmio_wr_data;
    logic            mmio_rd_valid;
    logic            mmio_rd_ready;
    logic [15:0]     mmio_rd_addr;
    logic [TW-1:0]   mmio_rd_tid;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [TW-1:0]   rsp_tid;
    logic [63:0]     rsp_data;
    logic [NUM*DW-1:0] rd_csr_data;
    logic [NUM-1:0]  wr_csr_en;
    logic [DW-1:0]   wr_csr_data;

    logic [DW-1:0]   csr_v [NUM];

    int n_chk;
    int n_fail;

    test_csr_bank #(
        .NUM_CSRS   (NUM),
        .DATA_WIDTH (DW),
        .TID_WIDTH  (TW),
        .RSP_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .afu_id        (afu_id),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_wr_addr  (mmio_wr_addr),
        .mmio_wr_data  (mmio_wr_data),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_rd_ready (mmio_rd_ready),
        .mmio_rd_addr  (mmio_rd_addr),
        .mmio_rd_tid   (mmio_rd_tid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_tid       (rsp_tid),
        .rsp_data      (rsp_data),
        .rd_csr_data   (rd_csr_data),
        .wr_csr_en     (wr_csr_en),
        .wr_csr_data   (wr_csr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the per-CSR test values onto the flat input bus.
    always_comb begin
        rd_csr_data = '0;
        for (int i = 0; i < NUM; i++) begin
            rd_csr_data[i*DW +: DW] = csr_v[i];
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        logic [7:0]  exp_en;
        logic [39:0] exp_dat;
    } wr_vec_t;

    typedef struct {
        logic [15:0]   addr;
        logic [TW-1:0] tid;
        logic [63:0]   exp;
    } rd_vec_t;

    wr_vec_t wv [5];
    rd_vec_t rv [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single isolated read with an empty queue and rsp_ready high.
    task automatic do_read(input string name, input logic [15:0] addr,
                           input logic [TW-1:0] tid, input logic [63:0] exp);
        mmio_rd_valid = 1'b1;
        mmio_rd_addr  = addr;
        mmio_rd_tid   = tid;
        chk({name, "_rdy"}, 64'(mmio_rd_ready), 64'd1);
        step();
        mmio_rd_valid = 1'b0;
        chk({name, "_lat1"}, 64'(rsp_valid), 64'd0);
        step();
        chk({name, "_vld"}, 64'(rsp_valid), 64'd1);
        chk({name, "_tid"}, 64'(rsp_tid), 64'(tid));
        chk({name, "_dat"}, rsp_data, exp);
        step();
        chk({name, "_pop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int got;
        logic [63:0] snap_exp;

        n_chk = 0;
        n_fail = 0;
        reset_n       = 1'b0;
        afu_id        = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        mmio_wr_valid = 1'b0;
        mmio_wr_addr  = '0;
        mmio_wr_data  = '0;
        mmio_rd_valid = 1'b0;
        mmio_rd_addr  = '0;
        mmio_rd_tid   = '0;
        rsp_ready     = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            csr_v[i] = {8'(8'hA0 + i), 32'h1234_5600 + 32'(i)};
        end
        csr_v[7] = 40'hFF_FFFF_FFFF;

        wv[0] = '{16'd5,  64'hDEAD_BEEF_0000_0005, 8'h08, 40'hEF_0000_0005};
        wv[1] = '{16'd10, 64'h0000_0000_0000_1111, 8'h00, 40'h0};
        wv[2] = '{16'd1,  64'h0000_0000_0000_2222, 8'h00, 40'h0};
        wv[3] = '{16'd9,  64'h0123_4567_89AB_CDEF, 8'h80, 40'h67_89AB_CDEF};
        wv[4] = '{16'd0,  64'h0000_0000_0000_3333, 8'h00, 40'h0};

        rv[0] = '{16'd2,     9'd1,   64'(csr_v[0])};
        rv[1] = '{16'd0,     9'd3,   64'hFEDC_BA98_7654_3210};
        rv[2] = '{16'd1,     9'd4,   64'h0123_4567_89AB_CDEF};
        rv[3] = '{16'd9,     9'd5,   64'h0000_00FF_FFFF_FFFF};
        rv[4] = '{16'd200,   9'd6,   64'h0};
        rv[5] = '{16'd10,    9'd8,   64'h0};
        rv[6] = '{16'd4,     9'd9,   64'(csr_v[2])};
        rv[7] = '{16'hFFFF,  9'h1FF, 64'h0};

        // Reset values.
        #2;
        chk("rst_rdy", 64'(mmio_rd_ready), 64'd0);
        chk("rst_rsp_vld", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_tid", 64'(rsp_tid), 64'd0);
        chk("rst_rsp_dat", rsp_data, 64'd0);
        chk("rst_wr_en", 64'(wr_csr_en), 64'd0);
        chk("rst_wr_dat", 64'(wr_csr_data), 64'd0);
        step();
        step();
        chk("rst_rdy_held", 64'(mmio_rd_ready), 64'd0);
        reset_n = 1'b1;
        chk("rst_rdy_release", 64'(mmio_rd_ready), 64'd0);
        step();
        chk("rdy_after_edge", 64'(mmio_rd_ready), 64'd1);

        // Write table.
        for (int k = 0; k < 5; k++) begin
            mmio_wr_valid = 1'b1;
            mmio_wr_addr  = wv[k].addr;
            mmio_wr_data  = wv[k].data;
            step();
            mmio_wr_valid = 1'b0;
            chk($sformatf("wr%0d_en", k), 64'(wr_csr_en), 64'(wv[k].exp_en));
            if (wv[k].exp_en != 8'h00) begin
                chk($sformatf("wr%0d_dat", k), 64'(wr_csr_data), 64'(wv[k].exp_dat));
            end
            step();
            chk($sformatf("wr%0d_clr", k), 64'(wr_csr_en), 64'd0);
        end

        // Back-to-back writes give back-to-back strobes.
        mmio_wr_valid = 1'b1;
        mmio_wr_addr  = 16'd2;
        mmio_wr_data  = 64'h0000_00AA_0000_0001;
        step();
        mmio_wr_addr  = 16'd3;
        mmio_wr_data  = 64'h0000_00BB_0000_0002;
        chk("b2b_en0", 64'(wr_csr_en), 64'h01);
        chk("b2b_dat0", 64'(wr_csr_data), 64'h00AA_0000_0001);
        step();
        mmio_wr_valid = 1'b0;
        chk("b2b_en1", 64'(wr_csr_en), 64'h02);
        chk("b2b_dat1", 64'(wr_csr_data), 64'h00BB_0000_0002);
        step();
        chk("b2b_clr", 64'(wr_csr_en), 64'd0);

        // Read table.
        for (int k = 0; k < 8; k++) begin
            do_read($sformatf("rd%0d", k), rv[k].addr, rv[k].tid, rv[k].exp);
        end

        // Back-to-back reads of words 0 and 1, with a simultaneous write.
        mmio_rd_valid = 1'b1;
        mmio_rd_addr  = 16'd0;
        mmio_rd_tid   = 9'd3;
        mmio_wr_valid = 1'b1;
        mmio_wr_addr  = 16'd4;
        mmio_wr_data  = 64'h55;
        step();
        mmio_wr_valid = 1'b0;
        chk("rw_en", 64'(wr_csr_en), 64'h04);
        chk("b2b_rd_rdy", 64'(mmio_rd_ready), 64'd1);
        mmio_rd_addr  = 16'd1;
        mmio_rd_tid   = 9'd4;
        step();
        mmio_rd_valid = 1'b0;
        chk("b2b_rd0_vld", 64'(rsp_valid), 64'd1);
        chk("b2b_rd0_tid", 64'(rsp_tid), 64'd3);
        chk("b2b_rd0_dat", rsp_data, 64'hFEDC_BA98_7654_3210);
        step();
        chk("b2b_rd1_vld", 64'(rsp_valid), 64'd1);
        chk("b2b_rd1_tid", 64'(rsp_tid), 64'd4);
        chk("b2b_rd1_dat", rsp_data, 64'h0123_4567_89AB_CDEF);
        step();
        chk("b2b_rd_empty", 64'(rsp_valid), 64'd0);

        // Backpressure: 6 reads against a stalled response port.
        rsp_ready = 1'b0;
        acc = 0;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (acc < 6) begin
                mmio_rd_valid = 1'b1;
                mmio_rd_addr  = 16'(2 + acc);
                mmio_rd_tid   = TW'(20 + acc);
            end else begin
                mmio_rd_valid = 1'b0;
            end
            if (c == 9) begin
                chk("bp_accepts", 64'(acc), 64'd4);
                chk("bp_rdy_low", 64'(mmio_rd_ready), 64'd0);
                chk("bp_head_tid", 64'(rsp_tid), 64'd20);
                chk("bp_head_dat", rsp_data, 64'(csr_v[0]));
                rsp_ready = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                if (got < 6) begin
                    chk($sformatf("bp_tid%0d", got), 64'(rsp_tid), 64'(20 + got));
                    chk($sformatf("bp_dat%0d", got), rsp_data, 64'(csr_v[got]));
                end
                got++;
            end
            if (mmio_rd_valid && mmio_rd_ready) begin
                acc++;
            end
            step();
        end
        mmio_rd_valid = 1'b0;
        chk("bp_total_acc", 64'(acc), 64'd6);
        chk("bp_total_rsp", 64'(got), 64'd6);
        chk("bp_drained", 64'(rsp_valid), 64'd0);

        // Snapshot coherence.
`ifdef TEST_CSR_SNAPSHOT_EN
        snap_exp = 64'd10;
`else
        snap_exp = 64'd20;
`endif
        csr_v[3] = 40'd10;
        do_read("snap_c0a", 16'd2, 9'd11, 64'(csr_v[0]));
        csr_v[3] = 40'd20;
        do_read("snap_w5a", 16'd5, 9'd12, snap_exp);
        do_read("snap_c0b", 16'd2, 9'd13, 64'(csr_v[0]));
        do_read("snap_w5b", 16'd5, 9'd14, 64'd20);

        // Reset with 3 queued responses and a pending write strobe.
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mmio_rd_valid = 1'b1;
            mmio_rd_addr  = 16'd0;
            mmio_rd_tid   = TW'(30 + k);
            step();
        end
        mmio_rd_valid = 1'b0;
        mmio_wr_valid = 1'b1;
        mmio_wr_addr  = 16'd2;
        mmio_wr_data  = 64'h77;
        step();
        mmio_wr_valid = 1'b0;
        chk("rq_vld_pre", 64'(rsp_valid), 64'd1);
        chk("rq_en_pre", 64'(wr_csr_en), 64'h01);
        reset_n = 1'b0;
        #1;
        chk("rq_vld_in_rst", 64'(rsp_valid), 64'd0);
        chk("rq_en_in_rst", 64'(wr_csr_en), 64'd0);
        chk("rq_rdy_in_rst", 64'(mmio_rd_ready), 64'd0);
        step();
        step();
        chk("rq_vld_held", 64'(rsp_valid), 64'd0);
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        chk("rq_rdy_release", 64'(mmio_rd_ready), 64'd0);
        step();
        chk("rq_rdy_edge", 64'(mmio_rd_ready), 64'd1);
        chk("rq_no_stale0", 64'(rsp_valid), 64'd0);
        step();
        chk("rq_no_stale1", 64'(rsp_valid), 64'd0);
        do_read("rq_tid7", 16'd4, 9'd7, 64'(csr_v[2]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
